// File: rtl/nivel_pkg.sv
// Shared definitions for the tank-level controller: FSM states, valid probe
// codes, fault codes and the probe-code decode helpers.
package nivel_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2,
      FAULT = 2'd3
   } state_e;

   localparam logic [2:0] CODE_EMPTY = 3'b000;
   localparam logic [2:0] CODE_LOW   = 3'b001;
   localparam logic [2:0] CODE_MID   = 3'b011;
   localparam logic [2:0] CODE_FULL  = 3'b111;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_INVALID = 2'b01;
   localparam logic [1:0] FC_TIMEOUT = 2'b10;

   // Probes are stacked, so only "filled from the bottom" patterns are physical.
   function automatic logic code_is_valid(input logic [2:0] code);
      return (code == CODE_EMPTY) || (code == CODE_LOW) ||
             (code == CODE_MID)   || (code == CODE_FULL);
   endfunction

   function automatic logic [1:0] code_to_nivel(input logic [2:0] code);
      logic [1:0] nivel;
      case (code)
         CODE_LOW:  nivel = 2'd1;
         CODE_MID:  nivel = 2'd2;
         CODE_FULL: nivel = 2'd3;
         default:   nivel = 2'd0;
      endcase
      return nivel;
   endfunction

endpackage

// File: rtl/nivel_tanque_ctrl_if.sv
// Probe/valve bus between the tank-level controller and its neighbours.
// Fault_Code only exists when NIVEL_FAULT_CODE_EN is defined.
interface nivel_tanque_ctrl_if;

   logic       H_raw;
   logic       M_raw;
   logic       L_raw;
   logic       Fill_En;
   logic       Err_Clr;
   logic       H;
   logic       M;
   logic       L;
   logic [1:0] Nivel;
   logic       Ve;
   logic       E;
`ifdef NIVEL_FAULT_CODE_EN
   logic [1:0] Fault_Code;

   modport master (
      output H_raw, M_raw, L_raw, Fill_En, Err_Clr,
      input  H, M, L, Nivel, Ve, E, Fault_Code
   );

   modport slave (
      input  H_raw, M_raw, L_raw, Fill_En, Err_Clr,
      output H, M, L, Nivel, Ve, E, Fault_Code
   );
`else
   modport master (
      output H_raw, M_raw, L_raw, Fill_En, Err_Clr,
      input  H, M, L, Nivel, Ve, E
   );

   modport slave (
      input  H_raw, M_raw, L_raw, Fill_En, Err_Clr,
      output H, M, L, Nivel, Ve, E
   );
`endif

endinterface

// File: rtl/nivel_debounce.sv
// One level probe: 2-flop synchroniser followed by a stability counter that
// only lets the output follow after DEB_CYCLES consecutive disagreeing samples.
module nivel_debounce #(
   parameter int DEB_CYCLES = 8
) (
   input  logic Clock,
   input  logic Reset,
   input  logic raw_in,
   output logic level_out
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any agreeing sample restarts the count, so short glitches never flip the output.
   always_comb begin
      sync1_d = raw_in;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_out = level_q;

endmodule

// File: rtl/nivel_tanque_ctrl.sv
// Tank-level stage: debounced probes, probe-code consistency check and the
// fill-valve FSM with hysteresis and fill timeout. NIVEL_FAULT_CODE_EN adds Fault_Code.
module nivel_tanque_ctrl
   import nivel_pkg::*;
#(
   parameter int DEB_CYCLES   = 8,
   parameter int ERR_PERSIST  = 4,
   parameter int FILL_TIMEOUT = 1024
) (
   input  logic                Clock,
   input  logic                Reset,
   nivel_tanque_ctrl_if.slave  bus
);

   localparam int IW   = $clog2(ERR_PERSIST + 1);
   localparam int TO_W = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;

   logic            h_deb, m_deb, l_deb;
   logic [2:0]      code;
   logic            code_ok;
   logic [1:0]      nivel_now;
   logic            nivel_rise;
   logic            inv_fault;
   logic            timeout_hit;

   logic [1:0]      nivel_q, nivel_d;
   logic [IW-1:0]   inv_cnt_q, inv_cnt_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   state_e          state_q, state_d;
   logic            ve_q, ve_d;
   logic            e_q, e_d;

   nivel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_h (
      .Clock     (Clock),
      .Reset     (Reset),
      .raw_in    (bus.H_raw),
      .level_out (h_deb)
   );

   nivel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_m (
      .Clock     (Clock),
      .Reset     (Reset),
      .raw_in    (bus.M_raw),
      .level_out (m_deb)
   );

   nivel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
      .Clock     (Clock),
      .Reset     (Reset),
      .raw_in    (bus.L_raw),
      .level_out (l_deb)
   );

   // nivel_q remembers the last valid level, which is also last cycle's Nivel.
   assign code        = {h_deb, m_deb, l_deb};
   assign code_ok     = code_is_valid(code);
   assign nivel_now   = code_ok ? code_to_nivel(code) : nivel_q;
   assign nivel_rise  = (nivel_now > nivel_q);
   assign inv_fault   = !code_ok && (inv_cnt_q == IW'(ERR_PERSIST - 1));
   assign timeout_hit = (to_cnt_q == TO_W'(FILL_TIMEOUT - 1));

   // The invalid counter parks at ERR_PERSIST so inv_fault fires exactly once per episode.
   always_comb begin
      nivel_d   = nivel_now;
      inv_cnt_d = '0;
      if (!code_ok) begin
         inv_cnt_d = (inv_cnt_q == IW'(ERR_PERSIST)) ? inv_cnt_q : inv_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (inv_fault) begin
               state_d = FAULT;
            end else if (bus.Fill_En && (nivel_now <= 2'd1)) begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (inv_fault || timeout_hit) begin
               state_d = FAULT;
            end else if (nivel_now == 2'd3) begin
               state_d = FULL;
            end else if (!bus.Fill_En) begin
               state_d = IDLE;
            end
         end
         FULL: begin
            if (inv_fault) begin
               state_d = FAULT;
            end else if (bus.Fill_En && (nivel_now <= 2'd1)) begin
               state_d = FILL;
            end else if (!bus.Fill_En) begin
               state_d = IDLE;
            end
         end
         FAULT: begin
            if (bus.Err_Clr && code_ok) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      ve_d = (state_d == FILL);
      e_d  = (state_d == FAULT);
   end

   // The timeout counter only runs while staying in FILL; entering FILL starts it from zero.
   always_comb begin
      to_cnt_d = '0;
      if ((state_q == FILL) && (state_d == FILL) && !nivel_rise) begin
         to_cnt_d = timeout_hit ? to_cnt_q : to_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         nivel_q   <= 2'd0;
         inv_cnt_q <= '0;
         to_cnt_q  <= '0;
         state_q   <= IDLE;
         ve_q      <= 1'b0;
         e_q       <= 1'b0;
      end else begin
         nivel_q   <= nivel_d;
         inv_cnt_q <= inv_cnt_d;
         to_cnt_q  <= to_cnt_d;
         state_q   <= state_d;
         ve_q      <= ve_d;
         e_q       <= e_d;
      end
   end

   assign bus.H     = h_deb;
   assign bus.M     = m_deb;
   assign bus.L     = l_deb;
   assign bus.Nivel = nivel_now;
   assign bus.Ve    = ve_q;
   assign bus.E     = e_q;

`ifdef NIVEL_FAULT_CODE_EN
   logic [1:0] fc_q, fc_d;

   // Only FILL can time out; every other FAULT entry is an invalid-code fault.
   always_comb begin
      fc_d = fc_q;
      if (state_d != FAULT) begin
         fc_d = FC_NONE;
      end else if (state_q != FAULT) begin
         fc_d = inv_fault ? FC_INVALID : FC_TIMEOUT;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         fc_q <= FC_NONE;
      end else begin
         fc_q <= fc_d;
      end
   end

   assign bus.Fault_Code = fc_q;
`endif

endmodule

// File: tb/tb_nivel_tanque_ctrl.sv
// Self-checking bench for nivel_tanque_ctrl with DEB_CYCLES=8, ERR_PERSIST=4,
// FILL_TIMEOUT=16; Fault_Code is also checked when NIVEL_FAULT_CODE_EN is defined.
module tb_nivel_tanque_ctrl;

   logic Clock;
   logic Reset;
   int   checks;
   int   errors;

   nivel_tanque_ctrl_if bus ();

   nivel_tanque_ctrl #(
      .DEB_CYCLES   (8),
      .ERR_PERSIST  (4),
      .FILL_TIMEOUT (16)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic [2:0] probes;
      logic       fill_en;
      int         wait_cycles;
      logic [2:0] exp_hml;
      logic [1:0] exp_nivel;
      logic       exp_ve;
      logic       exp_e;
   } vec_t;

   vec_t vecs[8];

   task automatic step(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      {bus.H_raw, bus.M_raw, bus.L_raw} = v.probes;
      bus.Fill_En = v.fill_en;
      step(v.wait_cycles);
   endtask

   task automatic pulseErrClr();
      bus.Err_Clr = 1'b1;
      step(1);
      bus.Err_Clr = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // probes, fill_en, wait, {H,M,L}, Nivel, Ve, E
      vecs[0] = '{3'b000, 1'b1,  2, 3'b000, 2'd0, 1'b1, 1'b0};
      vecs[1] = '{3'b001, 1'b1, 12, 3'b001, 2'd1, 1'b1, 1'b0};
      vecs[2] = '{3'b011, 1'b1, 12, 3'b011, 2'd2, 1'b1, 1'b0};
      vecs[3] = '{3'b111, 1'b1, 12, 3'b111, 2'd3, 1'b0, 1'b0};
      vecs[4] = '{3'b011, 1'b1, 12, 3'b011, 2'd2, 1'b0, 1'b0};
      vecs[5] = '{3'b001, 1'b1, 12, 3'b001, 2'd1, 1'b1, 1'b0};
      vecs[6] = '{3'b001, 1'b0,  2, 3'b001, 2'd1, 1'b0, 1'b0};
      vecs[7] = '{3'b000, 1'b0, 12, 3'b000, 2'd0, 1'b0, 1'b0};

      Reset       = 1'b1;
      bus.H_raw   = 1'b0;
      bus.M_raw   = 1'b0;
      bus.L_raw   = 1'b0;
      bus.Fill_En = 1'b0;
      bus.Err_Clr = 1'b0;
      #1;
      checkOutput("reset_hml", {bus.H, bus.M, bus.L}, 3'b000);
      checkOutput("reset_nivel", {1'b0, bus.Nivel}, 3'd0);
      checkOutput("reset_ve", {2'b0, bus.Ve}, 3'd0);
      checkOutput("reset_e", {2'b0, bus.E}, 3'd0);
`ifdef NIVEL_FAULT_CODE_EN
      checkOutput("reset_fc", {1'b0, bus.Fault_Code}, 3'd0);
`endif
      step(2);
      Reset = 1'b0;
      step(1);

      // Fill cycle with hysteresis, driven from the vector table.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_hml", i), {bus.H, bus.M, bus.L}, vecs[i].exp_hml);
         checkOutput($sformatf("vec%0d_nivel", i), {1'b0, bus.Nivel}, {1'b0, vecs[i].exp_nivel});
         checkOutput($sformatf("vec%0d_ve", i), {2'b0, bus.Ve}, {2'b0, vecs[i].exp_ve});
         checkOutput($sformatf("vec%0d_e", i), {2'b0, bus.E}, {2'b0, vecs[i].exp_e});
      end

      // Glitch rejection on M with the tank at low level.
      bus.L_raw = 1'b1;
      step(12);
      checkOutput("glitch_pre_l", {2'b0, bus.L}, 3'd1);
      bus.M_raw = 1'b1;
      step(5);
      bus.M_raw = 1'b0;
      for (int i = 0; i < 15; i++) begin
         checkOutput($sformatf("glitch5_m_c%0d", i), {2'b0, bus.M}, 3'd0);
         step(1);
      end
      bus.M_raw = 1'b1;
      step(9);
      checkOutput("glitch12_m_c9", {2'b0, bus.M}, 3'd0);
      step(1);
      checkOutput("glitch12_m_c10", {2'b0, bus.M}, 3'd1);
      checkOutput("glitch12_nivel", {1'b0, bus.Nivel}, 3'd2);
      step(2);
      bus.M_raw = 1'b0;
      step(9);
      checkOutput("glitch12_fall_c9", {2'b0, bus.M}, 3'd1);
      step(1);
      checkOutput("glitch12_fall_c10", {2'b0, bus.M}, 3'd0);

      // Invalid code 101 from IDLE: H settles after 10 edges, fault 4 invalid cycles later.
      bus.H_raw = 1'b1;
      step(13);
      checkOutput("inv_e_before", {2'b0, bus.E}, 3'd0);
      step(1);
      checkOutput("inv_e", {2'b0, bus.E}, 3'd1);
      checkOutput("inv_ve", {2'b0, bus.Ve}, 3'd0);
      checkOutput("inv_nivel_hold", {1'b0, bus.Nivel}, 3'd1);
`ifdef NIVEL_FAULT_CODE_EN
      checkOutput("inv_fc", {1'b0, bus.Fault_Code}, 3'd1);
`endif
      pulseErrClr();
      step(2);
      checkOutput("inv_clr_ignored", {2'b0, bus.E}, 3'd1);
      bus.H_raw = 1'b0;
      step(12);
      checkOutput("inv_restored_h", {2'b0, bus.H}, 3'd0);
      checkOutput("inv_e_held", {2'b0, bus.E}, 3'd1);
      pulseErrClr();
      checkOutput("inv_cleared_e", {2'b0, bus.E}, 3'd0);
`ifdef NIVEL_FAULT_CODE_EN
      checkOutput("inv_cleared_fc", {1'b0, bus.Fault_Code}, 3'd0);
`endif

      // Fill timeout with the tank stuck empty.
      bus.L_raw = 1'b0;
      step(12);
      checkOutput("to_empty_nivel", {1'b0, bus.Nivel}, 3'd0);
      bus.Fill_En = 1'b1;
      step(1);
      checkOutput("to_fill_ve", {2'b0, bus.Ve}, 3'd1);
      step(15);
      checkOutput("to_e_c15", {2'b0, bus.E}, 3'd0);
      step(1);
      checkOutput("to_e_c16", {2'b0, bus.E}, 3'd1);
      checkOutput("to_ve_c16", {2'b0, bus.Ve}, 3'd0);
`ifdef NIVEL_FAULT_CODE_EN
      checkOutput("to_fc", {1'b0, bus.Fault_Code}, 3'd2);
`endif
      bus.Fill_En = 1'b0;
      pulseErrClr();
      checkOutput("to_cleared_e", {2'b0, bus.E}, 3'd0);

      // Timeout restarted by a level rise ten cycles into FILL.
      bus.Fill_En = 1'b1;
      step(1);
      checkOutput("rise_fill_ve", {2'b0, bus.Ve}, 3'd1);
      bus.L_raw = 1'b1;
      step(9);
      checkOutput("rise_l_c9", {2'b0, bus.L}, 3'd0);
      step(1);
      checkOutput("rise_l_c10", {2'b0, bus.L}, 3'd1);
      step(16);
      checkOutput("rise_e_c26", {2'b0, bus.E}, 3'd0);
      checkOutput("rise_ve_c26", {2'b0, bus.Ve}, 3'd1);
      step(1);
      checkOutput("rise_e_c27", {2'b0, bus.E}, 3'd1);
`ifdef NIVEL_FAULT_CODE_EN
      checkOutput("rise_fc", {1'b0, bus.Fault_Code}, 3'd2);
`endif

      // Asynchronous reset in the middle of a fill.
      pulseErrClr();
      step(1);
      checkOutput("rst_fill_ve", {2'b0, bus.Ve}, 3'd1);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("rst_async_ve", {2'b0, bus.Ve}, 3'd0);
      checkOutput("rst_async_e", {2'b0, bus.E}, 3'd0);
      bus.Fill_En = 1'b0;
      step(1);
      Reset = 1'b0;
      step(2);
      checkOutput("rst_after_ve", {2'b0, bus.Ve}, 3'd0);
      checkOutput("rst_after_e", {2'b0, bus.E}, 3'd0);
      checkOutput("rst_after_nivel", {1'b0, bus.Nivel}, 3'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nivel_tanque_ctrl.md
Name: nivel_tanque_ctrl

Overview:
- Upstream tank-level stage of the irrigation controller.
- Synchronises and debounces the three raw level probes.
- Checks that the probe combination is physically consistent.
- Runs the fill valve with hysteresis and a fill timeout.
- Produces the conditioned H/M/L, valve request Ve and fault flag E consumed by the irrigation state machine downstream.

Parameters:
DEB_CYCLES, 8, consecutive stable samples required before a debounced level changes
ERR_PERSIST, 4, consecutive cycles an invalid probe code must persist before a fault
FILL_TIMEOUT, 1024, max cycles in FILL without the level rising before a timeout fault

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
H_raw  in  1  raw high-level probe, asynchronous
M_raw  in  1  raw mid-level probe, asynchronous
L_raw  in  1  raw low-level probe, asynchronous
Fill_En  in  1  system permission to fill, synchronous
Err_Clr  in  1  fault acknowledge, synchronous, sampled each cycle
H  out  1  debounced high level
M  out  1  debounced mid level
L  out  1  debounced low level
Nivel  out  2  level index: 0 empty, 1 low, 2 mid, 3 full
Ve  out  1  fill valve command, registered
E  out  1  fault flag, registered, sticky until cleared

Behaviour:
- Reset (async, active-high) values:
  - H, M, L, Ve, E = 0; Nivel = 0.
  - State IDLE; all counters 0; synchroniser flops 0.
  - Reset asserted mid-fill drops Ve immediately, without waiting for a clock edge.
- Synchroniser: each raw probe passes a 2-flop synchroniser.
- Debounce, per probe:
  - Counter increments while the synchronised sample differs from the debounced output.
  - Counter clears on any cycle where they agree.
  - When the counter reaches DEB_CYCLES-1 with disagreement still present, the output flips and the counter clears.
  - Latency from a clean raw edge to the H/M/L change is 2 + DEB_CYCLES cycles.
  - A glitch shorter than DEB_CYCLES cycles never propagates.
- Code check, code = {H,M,L}:
  - Valid codes: 000 (Nivel 0), 001 (Nivel 1), 011 (Nivel 2), 111 (Nivel 3).
  - Any other code is invalid; Nivel holds its last valid value.
  - Invalid counter increments each invalid cycle and clears on any valid cycle.
  - Reaching ERR_PERSIST raises inv_fault, a single-cycle internal event.
- FSM: states IDLE, FILL, FULL, FAULT. Ve=1 only in FILL; E=1 only in FAULT. Both are flops loaded with the next-state decode, so they change on the same edge as the state.
- IDLE:
  - inv_fault -> FAULT.
  - Else Fill_En and Nivel<=1 -> FILL.
  - Else stay.
- FILL, priority order:
  1. inv_fault -> FAULT.
  2. Timeout counter reaches FILL_TIMEOUT-1 -> FAULT.
  3. Nivel==3 -> FULL.
  4. !Fill_En -> IDLE.
  - Timeout counter clears on FILL entry and on every Nivel increase; it saturates and never wraps.
- FULL:
  - inv_fault -> FAULT.
  - Fill_En and Nivel<=1 -> FILL. Hysteresis: a drop to mid (Nivel 2) does not refill.
  - !Fill_En -> IDLE.
- FAULT:
  - Exits to IDLE only when Err_Clr=1 and the current code is valid.
  - Err_Clr while the code is still invalid is ignored.
  - Timeout and invalid counters clear on exit.
- Simultaneous Nivel==3 and timeout in FILL: timeout wins, go to FAULT.
- Fill_En deasserted in the same cycle as an inv_fault: go to FAULT.

Optional Feature:
- Macro NIVEL_FAULT_CODE_EN.
- Defined:
  - Adds output Fault_Code[1:0]: 01 invalid probe code, 10 fill timeout, 00 no fault.
  - Loaded on FAULT entry, held through FAULT, cleared on exit and on Reset.
- Undefined: port and its logic absent; E alone reports faults, with identical FSM behaviour.

Decomposition:
- Shared package/include nivel_pkg, holding:
  - state encodings (IDLE, FILL, FULL, FAULT);
  - valid code constants (CODE_EMPTY, CODE_LOW, CODE_MID, CODE_FULL);
  - fault code constants.
- One sub-module, nivel_debounce: 2-flop synchroniser plus counter with parameter DEB_CYCLES, instantiated three times.
- Code check, FSM and timeout logic stay in the top level.

Test Plan:
- Reset mid-FILL: assert Reset while Ve=1 -> Ve=0 and E=0 without a clock edge; state IDLE after release.
- Glitch rejection: DEB_CYCLES=8, M_raw pulse of 5 cycles -> M stays 0; pulse of 12 cycles -> M rises at cycle 10 after the edge.
- Fill cycle, Fill_En=1:
  - Probes step 000 -> 001 -> 011 -> 111 -> Ve=1 from IDLE, Ve=0 on Nivel 3, state FULL.
  - Drop to 011 -> Ve stays 0.
  - Drop to 001 -> Ve=1.
- Invalid code: force 101 for 4 stable debounced cycles -> E=1, Ve=0, Fault_Code=01 (macro on).
  - Err_Clr while 101 still present -> E stays 1.
  - Restore 001, pulse Err_Clr -> E=0 next cycle.
- Timeout: FILL_TIMEOUT=16, Fill_En=1, probes held at 000 -> E=1 after 16 cycles in FILL, Fault_Code=10.
  - Same run with a level rise at cycle 10 -> no fault until 16 cycles after the rise.
